// File: rtl/dd_timeout_scheduler_pkg.sv
// Shared dd_engine timing widths and helpers for the timeout scheduler.
// Holds the expiry FIFO depth default next to the timer widths.
package dd_timeout_scheduler_pkg;

    localparam int TIME_W           = 16;
    localparam int TIMER_W          = 16;
    localparam int DD_TO_FIFO_DEPTH = 4;

    function automatic int clogb2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dd_to_fifo.sv
// Small first-word-fall-through FIFO for expired flow IDs.
// Output is zero while empty; pointers carry one extra wrap bit.
module dd_to_fifo
    import dd_timeout_scheduler_pkg::*;
#(
    parameter int W     = 6,
    parameter int DEPTH = DD_TO_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = clogb2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr;
    logic [AW:0]  rd;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr == rd);
    assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr[AW-1:0]] <= din;
                wr              <= wr + 1'b1;
            end
            if (do_pop) rd <= rd + 1'b1;
        end
    end

endmodule

// File: rtl/dd_timeout_scheduler.sv
// Per-flow retransmission timer bank with round-robin expiry scan.
// Optional total expiry counter: define DD_TO_EXPIRY_CNT_EN.
module dd_timeout_scheduler
    import dd_timeout_scheduler_pkg::*;
#(
    parameter int FLOW_CNT   = 64,
    parameter int FLOW_ID_W  = clogb2(FLOW_CNT),
    parameter int FIFO_DEPTH = DD_TO_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TIME_W-1:0]    now,
    input  logic                 upd_val,
    input  logic [FLOW_ID_W-1:0] upd_fid,
    input  logic                 upd_arm,
    input  logic [TIMER_W-1:0]   upd_amnt,
    output logic                 to_val,
    output logic [FLOW_ID_W-1:0] to_fid,
    input  logic                 to_rdy
`ifdef DD_TO_EXPIRY_CNT_EN
    ,
    output logic [31:0]          expiry_cnt
`endif
);

    logic [FLOW_CNT-1:0]  armed;
    logic [TIME_W-1:0]    deadline [FLOW_CNT];
    logic [FLOW_ID_W-1:0] ptr;
    logic [TIME_W-1:0]    age;
    logic                 expired;
    logic                 collide;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;

    // Wrap-safe: expired once now has reached the deadline within half range
    assign age     = now - deadline[ptr];
    assign expired = armed[ptr] & ~age[TIME_W-1];
    assign collide = upd_val & (upd_fid == ptr);
    assign push    = expired & ~full & ~collide;
    assign pop     = to_val & to_rdy;
    assign to_val  = ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= '0;
        end else begin
            if (push) armed[ptr] <= 1'b0;
            if (upd_val) armed[upd_fid] <= upd_arm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FLOW_CNT; i++) deadline[i] <= '0;
        end else if (upd_val && upd_arm) begin
            deadline[upd_fid] <= now + TIME_W'(upd_amnt);
        end
    end

    // Hold on an expired flow only while the FIFO is full and no update races it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (~expired || ~full || collide) begin
            ptr <= ptr + FLOW_ID_W'(1);
        end
    end

`ifdef DD_TO_EXPIRY_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expiry_cnt <= '0;
        end else if (push) begin
            expiry_cnt <= expiry_cnt + 32'd1;
        end
    end
`else
`endif

    dd_to_fifo #(
        .W     (FLOW_ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (ptr),
        .pop   (pop),
        .dout  (to_fid),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_dd_timeout_scheduler.sv
// Directed bench for dd_timeout_scheduler (64 flows, 4-deep FIFO, 16-bit time).
// Checks expiry_cnt too when DD_TO_EXPIRY_CNT_EN is defined.
module tb_dd_timeout_scheduler;
    import dd_timeout_scheduler_pkg::*;

    localparam int FW = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [TIME_W-1:0] now;
    logic              upd_val;
    logic [FW-1:0]     upd_fid;
    logic              upd_arm;
    logic [TIMER_W-1:0] upd_amnt;
    logic              to_val;
    logic [FW-1:0]     to_fid;
    logic              to_rdy;
`ifdef DD_TO_EXPIRY_CNT_EN
    logic [31:0]       expiry_cnt;
`endif

    int tests = 0;
    int fails = 0;

    int                pulses;
    logic [TIME_W-1:0] first_now;
    logic [FW-1:0]     first_fid;
    logic [FW-1:0]     got [16];
    int                n;

    always #5 clk = ~clk;

    dd_timeout_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .now      (now),
        .upd_val  (upd_val),
        .upd_fid  (upd_fid),
        .upd_arm  (upd_arm),
        .upd_amnt (upd_amnt),
        .to_val   (to_val),
        .to_fid   (to_fid),
        .to_rdy   (to_rdy)
`ifdef DD_TO_EXPIRY_CNT_EN
        ,
        .expiry_cnt (expiry_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        now = now + 1'b1;
    endtask

    task automatic do_reset(input logic [TIME_W-1:0] t0, input logic rdy);
        rst      = 1'b1;
        upd_val  = 1'b0;
        upd_fid  = '0;
        upd_arm  = 1'b0;
        upd_amnt = '0;
        to_rdy   = rdy;
        @(posedge clk);
        #1;
        rst = 1'b0;
        now = t0;
    endtask

    task automatic upd(input logic [FW-1:0] fid, input logic arm,
                       input logic [TIMER_W-1:0] amnt);
        upd_val  = 1'b1;
        upd_fid  = fid;
        upd_arm  = arm;
        upd_amnt = amnt;
        tick();
        upd_val  = 1'b0;
    endtask

    task automatic watch(input int cycles);
        pulses    = 0;
        first_now = '0;
        first_fid = '0;
        for (int i = 0; i < cycles; i++) begin
            if (to_val) begin
                pulses++;
                if (pulses == 1) begin
                    first_now = now;
                    first_fid = to_fid;
                end
            end
            tick();
        end
    endtask

    initial begin
        now = '0;
        do_reset(16'd100, 1'b1);
        check("reset_to_val", 32'(to_val), 32'd0);
        check("reset_to_fid", 32'(to_fid), 32'd0);
`ifdef DD_TO_EXPIRY_CNT_EN
        check("reset_cnt", expiry_cnt, 32'd0);
`endif

        // Basic arm: deadline 120, flow 5 next scanned at now=169
        upd(6'd5, 1'b1, 16'd20);
        watch(100);
        check("basic_pulses", 32'(pulses), 32'd1);
        check("basic_fid", 32'(first_fid), 32'd5);
        check("basic_when", 32'(first_now), 32'd170);
`ifdef DD_TO_EXPIRY_CNT_EN
        check("basic_cnt", expiry_cnt, 32'd1);
`endif

        // Disarm before deadline
        do_reset(16'd100, 1'b1);
        upd(6'd3, 1'b1, 16'd10);
        while (now != 16'd105) tick();
        upd(6'd3, 1'b0, 16'd0);
        watch(200);
        check("disarm_pulses", 32'(pulses), 32'd0);

        // Wrap: deadline 0x0010, flow 0 rescanned at now=0x0030
        do_reset(16'hFFF0, 1'b1);
        upd(6'd0, 1'b1, 16'h0020);
        pulses = 0;
        for (int i = 0; i < 40 && now != 16'h0010; i++) begin
            if (to_val) pulses++;
            tick();
        end
        check("wrap_early", 32'(pulses), 32'd0);
        watch(70);
        check("wrap_pulses", 32'(pulses), 32'd1);
        check("wrap_fid", 32'(first_fid), 32'd0);
        check("wrap_when", 32'(first_now), 32'h0031);

        // Backpressure: 8 flows expire, FIFO fills with 0..3 and scanner stalls
        do_reset(16'd1000, 1'b0);
        for (int i = 0; i < 8; i++) upd(FW'(i), 1'b1, 16'd0);
        for (int i = 0; i < 70; i++) tick();
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_val", 32'(to_val), 32'd1);
            check("bp_hold_fid", 32'(to_fid), 32'd0);
            tick();
        end
`ifdef DD_TO_EXPIRY_CNT_EN
        check("bp_stall_cnt", expiry_cnt, 32'd4);
`endif
        to_rdy = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (to_val && n < 16) begin
                got[n] = to_fid;
                n++;
            end
            tick();
        end
        check("bp_count", 32'(n), 32'd8);
        for (int i = 0; i < 8; i++) check("bp_order", 32'(got[i]), 32'(i));
`ifdef DD_TO_EXPIRY_CNT_EN
        check("bp_cnt", expiry_cnt, 32'd8);
`endif

        // Collision: flow 9 expired at its scan while rearmed to 2059
        do_reset(16'd2000, 1'b1);
        upd(6'd9, 1'b1, 16'd0);
        for (int i = 0; i < 8; i++) tick();
        upd(6'd9, 1'b1, 16'd50);
        check("coll_no_push", 32'(to_val), 32'd0);
        watch(100);
        check("coll_pulses", 32'(pulses), 32'd1);
        check("coll_fid", 32'(first_fid), 32'd9);
        check("coll_when", 32'(first_now), 32'd2074);

        // Reset mid-stream with 3 entries queued
        do_reset(16'd3000, 1'b0);
        for (int i = 0; i < 3; i++) upd(FW'(i), 1'b1, 16'd0);
        for (int i = 0; i < 70; i++) tick();
        check("mid_val", 32'(to_val), 32'd1);
`ifdef DD_TO_EXPIRY_CNT_EN
        check("mid_cnt", expiry_cnt, 32'd3);
`endif
        #2;
        rst = 1'b1;
        #1;
        check("arst_val", 32'(to_val), 32'd0);
        check("arst_fid", 32'(to_fid), 32'd0);
`ifdef DD_TO_EXPIRY_CNT_EN
        check("arst_cnt", expiry_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst    = 1'b0;
        to_rdy = 1'b1;
        watch(150);
        check("arst_disarmed", 32'(pulses), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
